// File: rtl/myproject_dense_acc_if.sv
//------------------------------------------------------------------------------
// Module   : myproject_dense_acc_if
// Purpose  : Product-in / result-out bus between multiplier array and
//            activation FIFO, plus the neuron bias and count-error flag.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface myproject_dense_acc_if #(
   parameter int PROD_W = 10,
   parameter int OUT_W  = 8
);
   logic signed [PROD_W-1:0] prod_dat;
   logic                     prod_vld;
   logic                     prod_rdy;
   logic                     prod_last;
   logic signed [OUT_W-1:0]  bias;
   logic signed [OUT_W-1:0]  res_dat;
   logic                     res_vld;
   logic                     res_rdy;
   logic                     cnt_err;

   modport master (
      output prod_dat, prod_vld, prod_last, bias, res_rdy,
      input  prod_rdy, res_dat, res_vld, cnt_err
   );

   modport slave (
      input  prod_dat, prod_vld, prod_last, bias, res_rdy,
      output prod_rdy, res_dat, res_vld, cnt_err
   );
endinterface

`default_nettype wire

// File: rtl/myproject_dense_acc.sv
//------------------------------------------------------------------------------
// Module   : myproject_dense_acc
// Purpose  : Accumulates N_IN signed products, adds bias, saturates to OUT_W.
//            Optional ReLU after saturation: MYPROJECT_DENSE_ACC_RELU_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module myproject_dense_acc #(
   parameter int PROD_W = 10,
   parameter int N_IN   = 16,
   parameter int ACC_W  = 16,
   parameter int OUT_W  = 8,
   parameter int CNT_W  = 5
) (
   input  wire logic             ap_clk,
   input  wire logic             ap_rst,
   myproject_dense_acc_if.slave  bus
);

   typedef enum logic [1:0] {
      S_ACCUM = 2'd0,
      S_BIAS  = 2'd1,
      S_OUT   = 2'd2
   } state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));
   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(N_IN - 1);

   state_t                   state_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic [CNT_W-1:0]         cnt_q;
   logic                     prod_rdy_q;
   logic signed [OUT_W-1:0]  res_dat_q;
   logic                     res_vld_q;
   logic                     cnt_err_q;

   logic signed [ACC_W-1:0]  prod_ext_d;
   logic signed [ACC_W-1:0]  bias_ext_d;
   logic signed [ACC_W-1:0]  sum_bias_d;
   logic signed [OUT_W-1:0]  sat_d;
   logic signed [OUT_W-1:0]  res_d;
   logic                     accept_d;
   logic                     last_pos_d;

   assign prod_ext_d = {{(ACC_W-PROD_W){bus.prod_dat[PROD_W-1]}}, bus.prod_dat};
   assign bias_ext_d = {{(ACC_W-OUT_W){bus.bias[OUT_W-1]}}, bus.bias};
   assign sum_bias_d = acc_q + bias_ext_d;
   assign accept_d   = bus.prod_vld && prod_rdy_q;
   assign last_pos_d = (cnt_q == CNT_LAST);

   always_comb begin
      sat_d = sum_bias_d[OUT_W-1:0];
      if (sum_bias_d > SAT_MAX) begin
         sat_d = SAT_MAX[OUT_W-1:0];
      end else if (sum_bias_d < SAT_MIN) begin
         sat_d = SAT_MIN[OUT_W-1:0];
      end
   end

`ifdef MYPROJECT_DENSE_ACC_RELU_EN
   assign res_d = sat_d[OUT_W-1] ? '0 : sat_d;
`else
   assign res_d = sat_d;
`endif

   // Result is computed from acc+bias in BIAS so res_dat is registered on OUT entry.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q    <= S_ACCUM;
         acc_q      <= '0;
         cnt_q      <= '0;
         prod_rdy_q <= 1'b1;
         res_dat_q  <= '0;
         res_vld_q  <= 1'b0;
         cnt_err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_ACCUM: begin
               if (accept_d) begin
                  acc_q <= acc_q + prod_ext_d;
                  if (bus.prod_last != last_pos_d) begin
                     cnt_err_q <= 1'b1;
                  end
                  if (last_pos_d) begin
                     cnt_q      <= '0;
                     prod_rdy_q <= 1'b0;
                     state_q    <= S_BIAS;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            S_BIAS: begin
               acc_q     <= sum_bias_d;
               res_dat_q <= res_d;
               res_vld_q <= 1'b1;
               state_q   <= S_OUT;
            end
            S_OUT: begin
               if (bus.res_rdy) begin
                  acc_q      <= '0;
                  res_vld_q  <= 1'b0;
                  prod_rdy_q <= 1'b1;
                  state_q    <= S_ACCUM;
               end
            end
            default: begin
               state_q    <= S_ACCUM;
               prod_rdy_q <= 1'b1;
               res_vld_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.prod_rdy = prod_rdy_q;
   assign bus.res_dat  = res_dat_q;
   assign bus.res_vld  = res_vld_q;
   assign bus.cnt_err  = cnt_err_q;

endmodule

`default_nettype wire

// File: tb/tb_myproject_dense_acc.sv
//------------------------------------------------------------------------------
// Module   : tb_myproject_dense_acc
// Purpose  : Directed scoreboard bench for myproject_dense_acc (N_IN=4 and 16).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_myproject_dense_acc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              sel;
   logic              t_vld;
   logic              t_last;
   logic              t_rr;
   logic signed [9:0] t_dat;
   logic signed [7:0] t_bias;

   myproject_dense_acc_if #(.PROD_W(10), .OUT_W(8)) b4  ();
   myproject_dense_acc_if #(.PROD_W(10), .OUT_W(8)) b16 ();

   myproject_dense_acc #(.PROD_W(10), .N_IN(4), .ACC_W(16), .OUT_W(8), .CNT_W(3)) u4 (
      .ap_clk (clk),
      .ap_rst (rst),
      .bus    (b4)
   );

   myproject_dense_acc #(.PROD_W(10), .N_IN(16), .ACC_W(16), .OUT_W(8), .CNT_W(5)) u16 (
      .ap_clk (clk),
      .ap_rst (rst),
      .bus    (b16)
   );

   assign b4.prod_dat   = t_dat;
   assign b4.prod_last  = t_last;
   assign b4.bias       = t_bias;
   assign b4.res_rdy    = t_rr & ~sel;
   assign b4.prod_vld   = t_vld & ~sel;
   assign b16.prod_dat  = t_dat;
   assign b16.prod_last = t_last;
   assign b16.bias      = t_bias;
   assign b16.res_rdy   = t_rr & sel;
   assign b16.prod_vld  = t_vld & sel;

   logic              o_prdy;
   logic              o_vld;
   logic              o_err;
   logic signed [7:0] o_dat;

   assign o_prdy = sel ? b16.prod_rdy : b4.prod_rdy;
   assign o_vld  = sel ? b16.res_vld  : b4.res_vld;
   assign o_err  = sel ? b16.cnt_err  : b4.cnt_err;
   assign o_dat  = sel ? b16.res_dat  : b4.res_dat;

   int total = 0;
   int bad   = 0;
   int exp_q[$];

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic timeout(input string tag);
      total++;
      bad++;
      $display("FAIL %s: observed=timeout expected=event", tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Drive one beat at a negedge; returns at the negedge after it was accepted.
   task automatic send(input int v, input logic last);
      int n = 0;
      t_dat  = 10'(v);
      t_last = last;
      t_vld  = 1'b1;
      while (!o_prdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!o_prdy) begin
         timeout("send_rdy");
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
      t_vld  = 1'b0;
      t_last = 1'b0;
   endtask

   task automatic send4(input int a, input int b, input int c, input int d);
      send(a, 1'b0);
      send(b, 1'b0);
      send(c, 1'b0);
      send(d, 1'b1);
   endtask

   task automatic recv(input string tag);
      int n = 0;
      int e;
      e    = exp_q.pop_front();
      t_rr = 1'b1;
      while (!o_vld && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!o_vld) begin
         timeout(tag);
      end else begin
         check(tag, o_dat, e);
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; t_vld = 1'b0; t_last = 1'b0; t_rr = 1'b1;
      t_dat = '0; t_bias = '0;
      do_reset();

      check("rst_prod_rdy", o_prdy, 1);
      check("rst_res_vld",  o_vld,  0);
      check("rst_res_dat",  o_dat,  0);
      check("rst_cnt_err",  o_err,  0);

      // Basic neuron with latency checks
      t_bias = 8'sd3;
      exp_q.push_back(35);
      send4(10, 20, -5, 7);
      check("lat_bias_vld", o_vld, 0);
      check("lat_bias_rdy", o_prdy, 0);
      @(negedge clk);
      check("lat_out_vld", o_vld, 1);
      check("basic_sum", o_dat, exp_q.pop_front());
      @(negedge clk);
      check("post_xfer_vld", o_vld, 0);
      check("post_xfer_rdy", o_prdy, 1);
      check("basic_err", o_err, 0);

      // Saturation on the 16-input instance
      sel    = 1'b1;
      t_bias = 8'sd0;
      exp_q.push_back(127);
      for (int i = 0; i < 16; i++) send(511, i == 15);
      recv("sat_hi");
      t_bias = -8'sd1;
      exp_q.push_back(-128);
      for (int i = 0; i < 16; i++) send(-512, i == 15);
      recv("sat_lo");
      check("sat_err", o_err, 0);
      sel = 1'b0;

      // Output stall; a product offered meanwhile must not be absorbed
      t_bias = 8'sd0;
      t_rr   = 1'b0;
      exp_q.push_back(10);
      send4(1, 2, 3, 4);
      begin
         int n = 0;
         while (!o_vld && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      t_dat = 10'sd100;
      t_vld = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("stall_vld", o_vld, 1);
         check("stall_dat", o_dat, 10);
         check("stall_rdy", o_prdy, 0);
         @(negedge clk);
      end
      t_vld = 1'b0;
      recv("stall_res");
      check("stall_post_vld", o_vld, 0);
      check("stall_post_rdy", o_prdy, 1);
      exp_q.push_back(4);
      send4(1, 1, 1, 1);
      recv("no_absorb");

      // prod_last early
      do_reset();
      exp_q.push_back(10);
      send(1, 1'b0);
      send(2, 1'b0);
      check("err_before", o_err, 0);
      send(3, 1'b1);
      check("err_set", o_err, 1);
      send(4, 1'b0);
      check("err_sticky", o_err, 1);
      recv("err_sum");
      check("err_after", o_err, 1);

      // Reset in the middle of a neuron
      do_reset();
      send(100, 1'b0);
      send(100, 1'b0);
      do_reset();
      check("midrst_err", o_err, 0);
      check("midrst_vld", o_vld, 0);
      exp_q.push_back(10);
      send4(1, 2, 3, 4);
      recv("midrst_sum");

      // Negative result, with or without ReLU
`ifdef MYPROJECT_DENSE_ACC_RELU_EN
      exp_q.push_back(0);
`else
      exp_q.push_back(-20);
`endif
      send4(-10, -5, -3, -2);
      recv("neg_res");
      check("final_err", o_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
